// File: rtl/dram_arb_pkg.sv
// Shared types for the DRAM request arbiter: per-channel FSM state and watchdog width.
// Watchdog logic exists only when DRAM_ARB_TIMEOUT_EN is defined.
package dram_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_BUSY,
    ARB_WAIT_DONE
  } arb_state_t;

  localparam int TIMEOUT_W = 16;
endpackage

// File: rtl/dram_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr (wrapping) wins.
module dram_arb_rr_pick
  import dram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic               any,
  output logic [IW-1:0]      idx,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    int cand;
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = 0;
    // Walk farthest-first so the nearest valid candidate after ptr is written last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (valid[cand]) begin
        any = 1'b1;
        idx = IW'(cand);
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/dram_request_arbiter.sv
// Shares one DRAM controller between NUM_REQ requesters with independent read/write channels.
// Define DRAM_ARB_TIMEOUT_EN to add a per-command watchdog of TIMEOUT_CYCLES.
module dram_request_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int DRAM_DATA_WIDTH = 512,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                                  m_axi_aclk,
  input  logic                                  m_axi_areset,
  input  logic [NUM_REQ-1:0]                    req_rd_valid,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]     req_rd_addr,
  input  logic [NUM_REQ*8-1:0]                  req_rd_len,
  output logic [NUM_REQ-1:0]                    req_rd_ready,
  output logic [DRAM_DATA_WIDTH-1:0]            req_rd_data,
  output logic [NUM_REQ-1:0]                    req_rd_data_valid,
  output logic [NUM_REQ-1:0]                    req_rd_err,
  input  logic [NUM_REQ-1:0]                    req_wr_valid,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]     req_wr_addr,
  input  logic [NUM_REQ*8-1:0]                  req_wr_len,
  input  logic [NUM_REQ*DRAM_DATA_WIDTH-1:0]    req_wr_data,
  output logic [NUM_REQ-1:0]                    req_wr_ready,
  output logic [NUM_REQ-1:0]                    req_wr_done,
  output logic [NUM_REQ-1:0]                    req_wr_err,
  output logic [AXI_ADDR_WIDTH-1:0]             dram_read_addr,
  output logic [7:0]                            dram_read_len,
  output logic                                  dram_read_en,
  output logic [AXI_ADDR_WIDTH-1:0]             dram_write_addr,
  output logic [7:0]                            dram_write_len,
  output logic                                  dram_write_en,
  output logic [DRAM_DATA_WIDTH-1:0]            dram_write_data,
  input  logic [DRAM_DATA_WIDTH-1:0]            dram_read_data,
  input  logic                                  dram_read_data_valid,
  input  logic                                  dram_read_busy,
  input  logic                                  dram_write_busy,
  output arb_state_t                            rd_state,
  output arb_state_t                            wr_state
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = DRAM_DATA_WIDTH;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_param_check
    $error("dram_request_arbiter: parameter out of range");
  end

  logic [IW-1:0]      rd_ptr, wr_ptr;
  logic               rd_any, wr_any;
  logic [IW-1:0]      rd_idx, wr_idx;
  logic [NUM_REQ-1:0] rd_oh, wr_oh;
  logic [NUM_REQ-1:0] rd_gnt, wr_gnt;
  logic [DW-1:0]      rd_cap;
  logic               rd_seen;
  logic               rd_to, wr_to;

  dram_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_rd_pick (
    .valid  (req_rd_valid),
    .ptr    (rd_ptr),
    .any    (rd_any),
    .idx    (rd_idx),
    .onehot (rd_oh)
  );

  dram_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_wr_pick (
    .valid  (req_wr_valid),
    .ptr    (wr_ptr),
    .any    (wr_any),
    .idx    (wr_idx),
    .onehot (wr_oh)
  );

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] rd_cnt, wr_cnt;

  // Counters restart while in ISSUE, i.e. on entry to the wait states.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_state == ARB_ISSUE) rd_cnt <= '0;
      else if (rd_state == ARB_WAIT_BUSY || rd_state == ARB_WAIT_DONE) rd_cnt <= rd_cnt + 1'b1;
      if (wr_state == ARB_ISSUE) wr_cnt <= '0;
      else if (wr_state == ARB_WAIT_BUSY || wr_state == ARB_WAIT_DONE) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  assign rd_to = (rd_state == ARB_WAIT_BUSY || rd_state == ARB_WAIT_DONE) && (rd_cnt == TO_LIMIT);
  assign wr_to = (wr_state == ARB_WAIT_BUSY || wr_state == ARB_WAIT_DONE) && (wr_cnt == TO_LIMIT);
`else
  assign rd_to = 1'b0;
  assign wr_to = 1'b0;
`endif

  // Read channel
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      rd_state          <= ARB_IDLE;
      rd_ptr            <= IW'(NUM_REQ - 1);
      rd_gnt            <= '0;
      rd_cap            <= '0;
      rd_seen           <= 1'b0;
      dram_read_addr    <= '0;
      dram_read_len     <= '0;
      dram_read_en      <= 1'b0;
      req_rd_ready      <= '0;
      req_rd_data       <= '0;
      req_rd_data_valid <= '0;
      req_rd_err        <= '0;
    end else begin
      req_rd_data_valid <= '0;
      req_rd_err        <= '0;
      // Last beat wins; the clear on a new issue below takes priority.
      if (rd_state != ARB_IDLE && dram_read_data_valid) begin
        rd_cap  <= dram_read_data;
        rd_seen <= 1'b1;
      end
      if (rd_to) begin
        rd_state   <= ARB_IDLE;
        rd_seen    <= 1'b0;
        req_rd_err <= rd_gnt;
      end else begin
        case (rd_state)
          ARB_IDLE: begin
            if (rd_any && !dram_read_busy) begin
              dram_read_addr <= req_rd_addr[rd_idx*AW +: AW];
              dram_read_len  <= req_rd_len[rd_idx*8 +: 8];
              dram_read_en   <= 1'b1;
              req_rd_ready   <= rd_oh;
              rd_gnt         <= rd_oh;
              rd_ptr         <= rd_idx;
              rd_seen        <= 1'b0;
              rd_state       <= ARB_ISSUE;
            end
          end
          ARB_ISSUE: begin
            dram_read_en <= 1'b0;
            req_rd_ready <= '0;
            rd_state     <= ARB_WAIT_BUSY;
          end
          ARB_WAIT_BUSY: begin
            if (dram_read_busy) rd_state <= ARB_WAIT_DONE;
          end
          ARB_WAIT_DONE: begin
            if (!dram_read_busy) begin
              if (rd_seen || dram_read_data_valid) begin
                req_rd_data       <= dram_read_data_valid ? dram_read_data : rd_cap;
                req_rd_data_valid <= rd_gnt;
              end else begin
                req_rd_err <= rd_gnt;
              end
              rd_state <= ARB_IDLE;
            end
          end
          default: rd_state <= ARB_IDLE;
        endcase
      end
    end
  end

  // Write channel
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      wr_state        <= ARB_IDLE;
      wr_ptr          <= IW'(NUM_REQ - 1);
      wr_gnt          <= '0;
      dram_write_addr <= '0;
      dram_write_len  <= '0;
      dram_write_en   <= 1'b0;
      dram_write_data <= '0;
      req_wr_ready    <= '0;
      req_wr_done     <= '0;
      req_wr_err      <= '0;
    end else begin
      req_wr_done <= '0;
      req_wr_err  <= '0;
      if (wr_to) begin
        wr_state   <= ARB_IDLE;
        req_wr_err <= wr_gnt;
      end else begin
        case (wr_state)
          ARB_IDLE: begin
            if (wr_any && !dram_write_busy) begin
              dram_write_addr <= req_wr_addr[wr_idx*AW +: AW];
              dram_write_len  <= req_wr_len[wr_idx*8 +: 8];
              dram_write_data <= req_wr_data[wr_idx*DW +: DW];
              dram_write_en   <= 1'b1;
              req_wr_ready    <= wr_oh;
              wr_gnt          <= wr_oh;
              wr_ptr          <= wr_idx;
              wr_state        <= ARB_ISSUE;
            end
          end
          ARB_ISSUE: begin
            dram_write_en <= 1'b0;
            req_wr_ready  <= '0;
            wr_state      <= ARB_WAIT_BUSY;
          end
          ARB_WAIT_BUSY: begin
            if (dram_write_busy) wr_state <= ARB_WAIT_DONE;
          end
          ARB_WAIT_DONE: begin
            if (!dram_write_busy) begin
              req_wr_done <= wr_gnt;
              wr_state    <= ARB_IDLE;
            end
          end
          default: wr_state <= ARB_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dram_request_arbiter.sv
// Scoreboard bench for dram_request_arbiter: directed requests, controller model, decoupled monitor.
// The watchdog scenario runs only when DRAM_ARB_TIMEOUT_EN is defined.
module tb_dram_request_arbiter;
  import dram_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct packed {
    logic          v;
    logic [7:0]    cyc;
    logic [DW-1:0] d;
  } mdl_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_rd_valid, req_rd_ready, req_rd_data_valid, req_rd_err;
  logic [N*AW-1:0]     req_rd_addr, req_wr_addr;
  logic [N*8-1:0]      req_rd_len, req_wr_len;
  logic [DW-1:0]       req_rd_data;
  logic [N-1:0]        req_wr_valid, req_wr_ready, req_wr_done, req_wr_err;
  logic [N*DW-1:0]     req_wr_data;
  logic [AW-1:0]       dram_read_addr, dram_write_addr;
  logic [7:0]          dram_read_len, dram_write_len;
  logic                dram_read_en, dram_write_en;
  logic [DW-1:0]       dram_write_data, dram_read_data;
  logic                dram_read_data_valid, dram_read_busy, dram_write_busy;
  arb_state_t          rd_state, wr_state;

  // Scoreboard queues: issue = {ready, addr, len[, data]}, completion = {kind, onehot[, data]}
  logic [N+AW+8-1:0]    rd_iss_q[$];
  logic [N+AW+8+DW-1:0] wr_iss_q[$];
  logic [2+N+DW-1:0]    rd_cpl_q[$];
  logic [2+N-1:0]       wr_cpl_q[$];
  mdl_t                 rd_mdl_q[$];
  mdl_t                 wr_mdl_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_rd_en_cyc = -1;
  int last_wr_en_cyc = -2;

  dram_request_arbiter #(
    .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .req_rd_valid(req_rd_valid), .req_rd_addr(req_rd_addr), .req_rd_len(req_rd_len),
    .req_rd_ready(req_rd_ready), .req_rd_data(req_rd_data),
    .req_rd_data_valid(req_rd_data_valid), .req_rd_err(req_rd_err),
    .req_wr_valid(req_wr_valid), .req_wr_addr(req_wr_addr), .req_wr_len(req_wr_len),
    .req_wr_data(req_wr_data), .req_wr_ready(req_wr_ready), .req_wr_done(req_wr_done),
    .req_wr_err(req_wr_err),
    .dram_read_addr(dram_read_addr), .dram_read_len(dram_read_len), .dram_read_en(dram_read_en),
    .dram_write_addr(dram_write_addr), .dram_write_len(dram_write_len),
    .dram_write_en(dram_write_en), .dram_write_data(dram_write_data),
    .dram_read_data(dram_read_data), .dram_read_data_valid(dram_read_data_valid),
    .dram_read_busy(dram_read_busy), .dram_write_busy(dram_write_busy),
    .rd_state(rd_state), .wr_state(wr_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name, input logic [127:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h, expected no such event", name, act);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Driver tasks: valid held until the matching ready is seen
  task automatic rd_req(input int i, input logic [AW-1:0] a, input logic [7:0] l);
    int t;
    req_rd_addr[i*AW +: AW] = a;
    req_rd_len[i*8 +: 8]    = l;
    req_rd_valid[i]         = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_rd_ready[i] && t < 200);
    if (!req_rd_ready[i]) unexp("rd_ready_never", 128'(i));
    req_rd_valid[i] = 1'b0;
  endtask

  task automatic wr_req(input int i, input logic [AW-1:0] a, input logic [7:0] l,
                        input logic [DW-1:0] d);
    int t;
    req_wr_addr[i*AW +: AW] = a;
    req_wr_len[i*8 +: 8]    = l;
    req_wr_data[i*DW +: DW] = d;
    req_wr_valid[i]         = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_wr_ready[i] && t < 200);
    if (!req_wr_ready[i]) unexp("wr_ready_never", 128'(i));
    req_wr_valid[i] = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int t;
    t = 0;
    while ((rd_cpl_q.size() != 0 || wr_cpl_q.size() != 0 ||
            rd_state != ARB_IDLE || wr_state != ARB_IDLE) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) unexp(name, 128'(rd_cpl_q.size() + wr_cpl_q.size()));
  endtask

  // DRAM controller model: busy for cyc cycles after en, optional data on the busy fall
  initial begin
    mdl_t m;
    dram_read_busy = 1'b0; dram_read_data_valid = 1'b0; dram_read_data = '0;
    forever begin
      @(negedge clk);
      if (dram_read_en && !rst) begin
        if (rd_mdl_q.size() == 0) unexp("rd_model_empty", 128'(dram_read_addr));
        else begin
          m = rd_mdl_q.pop_front();
          dram_read_busy = 1'b1;
          repeat (m.cyc) @(negedge clk);
          dram_read_busy = 1'b0; dram_read_data_valid = m.v; dram_read_data = m.d;
          @(negedge clk);
          dram_read_data_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    mdl_t m;
    dram_write_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (dram_write_en && !rst) begin
        if (wr_mdl_q.size() == 0) unexp("wr_model_empty", 128'(dram_write_addr));
        else begin
          m = wr_mdl_q.pop_front();
          dram_write_busy = 1'b1;
          repeat (m.cyc) @(negedge clk);
          dram_write_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents an issue or completion
  initial begin
    logic [2+N+DW-1:0] rc;
    logic [2+N-1:0]    wc;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (dram_read_en) begin
          last_rd_en_cyc = cyc;
          if (rd_iss_q.size() == 0) unexp("rd_issue", 128'({req_rd_ready, dram_read_addr}));
          else check("rd_issue", 128'({req_rd_ready, dram_read_addr, dram_read_len}),
                     128'(rd_iss_q.pop_front()));
        end else if (req_rd_ready != '0) check("rd_ready_without_en", 128'(req_rd_ready), 128'(0));
        if (dram_write_en) begin
          last_wr_en_cyc = cyc;
          if (wr_iss_q.size() == 0) unexp("wr_issue", 128'({req_wr_ready, dram_write_addr}));
          else check("wr_issue",
                     128'({req_wr_ready, dram_write_addr, dram_write_len, dram_write_data}),
                     128'(wr_iss_q.pop_front()));
        end else if (req_wr_ready != '0) check("wr_ready_without_en", 128'(req_wr_ready), 128'(0));
        if (req_rd_data_valid != '0 || req_rd_err != '0) begin
          rc = {|req_rd_err, |req_rd_data_valid, req_rd_data_valid | req_rd_err,
                (req_rd_data_valid != '0) ? req_rd_data : {DW{1'b0}}};
          if (rd_cpl_q.size() == 0) unexp("rd_completion", 128'(rc));
          else check("rd_completion", 128'(rc), 128'(rd_cpl_q.pop_front()));
        end
        if (req_wr_done != '0 || req_wr_err != '0) begin
          wc = {|req_wr_err, |req_wr_done, req_wr_done | req_wr_err};
          if (wr_cpl_q.size() == 0) unexp("wr_completion", 128'(wc));
          else check("wr_completion", 128'(wc), 128'(wr_cpl_q.pop_front()));
        end
      end
    end
  end

  function automatic logic [AW-1:0] cont_addr(input int i, input int c);
    return AW'(32'h2000 + i * 32'h100 + c * 32'h10);
  endfunction

  // Directed stimulus
  initial begin
    int cnt[N];
    int done, t;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rst = 1'b1;
    req_rd_valid = '0; req_rd_addr = '0; req_rd_len = '0;
    req_wr_valid = '0; req_wr_addr = '0; req_wr_len = '0; req_wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_rd_outputs", 128'({req_rd_ready, req_rd_data, req_rd_data_valid, req_rd_err,
                                    dram_read_addr, dram_read_len, dram_read_en}), 128'(0));
    check("reset_wr_outputs", 128'({req_wr_ready, req_wr_done, req_wr_err, dram_write_addr,
                                    dram_write_len, dram_write_en, dram_write_data}), 128'(0));
    check("reset_states", 128'({rd_state, wr_state}), 128'({ARB_IDLE, ARB_IDLE}));
    rst = 1'b0;
    @(negedge clk);

    // Single read from requester 0
    d = 64'hA5A5_0000_1000_0001;
    rd_iss_q.push_back({4'b0001, 32'h1000, 8'h00});
    rd_mdl_q.push_back('{v: 1'b1, cyc: 8'd3, d: d});
    rd_cpl_q.push_back({2'b01, 4'b0001, d});
    rd_req(0, 32'h1000, 8'h00);
    wait_quiet("single_read_quiet");

    // Contention from reset pointers: grants 0,1,2,3,0,1,2,3
    apply_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < N; i++) begin
        a = cont_addr(i, c);
        d = {32'hDA7A_0000 + 32'(c), a};
        rd_iss_q.push_back({4'(1 << i), a, 8'(i)});
        rd_mdl_q.push_back('{v: 1'b1, cyc: 8'd2, d: d});
        rd_cpl_q.push_back({2'b01, 4'(1 << i), d});
      end
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      req_rd_addr[i*AW +: AW] = cont_addr(i, 0);
      req_rd_len[i*8 +: 8]    = 8'(i);
    end
    req_rd_valid = '1;
    done = 0;
    t = 0;
    while (done < 2 * N && t < 400) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < N; i++)
        if (req_rd_ready[i]) begin
          cnt[i]++;
          done++;
          if (cnt[i] < 2) req_rd_addr[i*AW +: AW] = cont_addr(i, 1);
          else req_rd_valid[i] = 1'b0;
        end
    end
    check("contention_grants", 128'(done), 128'(2 * N));
    req_rd_valid = '0;
    wait_quiet("contention_quiet");

    // Concurrent: requester 1 write and requester 2 read in the same cycle
    d = 64'h0123_4567_89AB_CDEF;
    wr_iss_q.push_back({4'b0010, 32'h3000, 8'h03, d});
    wr_mdl_q.push_back('{v: 1'b0, cyc: 8'd4, d: '0});
    wr_cpl_q.push_back({2'b01, 4'b0010});
    rd_iss_q.push_back({4'b0100, 32'h4000, 8'h01});
    rd_mdl_q.push_back('{v: 1'b1, cyc: 8'd3, d: 64'hFEED_0000_0000_4000});
    rd_cpl_q.push_back({2'b01, 4'b0100, 64'hFEED_0000_0000_4000});
    fork
      rd_req(2, 32'h4000, 8'h01);
      wr_req(1, 32'h3000, 8'h03, d);
    join
    check("concurrent_same_cycle_en", 128'(last_rd_en_cyc), 128'(last_wr_en_cyc));
    wait_quiet("concurrent_quiet");

    // Read ends without data: error for requester 3
    rd_iss_q.push_back({4'b1000, 32'h5000, 8'h00});
    rd_mdl_q.push_back('{v: 1'b0, cyc: 8'd3, d: 64'hBAD});
    rd_cpl_q.push_back({2'b10, 4'b1000, {DW{1'b0}}});
    rd_req(3, 32'h5000, 8'h00);
    wait_quiet("rd_err_quiet");
    check("rd_err_state_idle", 128'(rd_state), 128'(ARB_IDLE));

    // Reset while waiting for the controller to finish
    rd_iss_q.push_back({4'b0001, 32'h6000, 8'h00});
    rd_mdl_q.push_back('{v: 1'b1, cyc: 8'd12, d: 64'h6666});
    rd_req(0, 32'h6000, 8'h00);
    t = 0;
    while (rd_state != ARB_WAIT_DONE && t < 50) begin @(negedge clk); t++; end
    check("midop_reached_wait_done", 128'(rd_state), 128'(ARB_WAIT_DONE));
    #2 rst = 1'b1;
    #1;
    check("midop_rd_outputs", 128'({req_rd_ready, req_rd_data, req_rd_data_valid, req_rd_err,
                                    dram_read_addr, dram_read_len, dram_read_en}), 128'(0));
    check("midop_wr_outputs", 128'({req_wr_ready, req_wr_done, req_wr_err, dram_write_addr,
                                    dram_write_len, dram_write_en, dram_write_data}), 128'(0));
    check("midop_states", 128'({rd_state, wr_state}), 128'({ARB_IDLE, ARB_IDLE}));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t = 0;
    while (dram_read_busy && t < 50) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    rd_iss_q.push_back({4'b0010, 32'h7000, 8'h02});
    rd_mdl_q.push_back('{v: 1'b1, cyc: 8'd3, d: 64'h7777_0000_0000_7000});
    rd_cpl_q.push_back({2'b01, 4'b0010, 64'h7777_0000_0000_7000});
    rd_req(1, 32'h7000, 8'h02);
    wait_quiet("after_reset_quiet");

`ifdef DRAM_ARB_TIMEOUT_EN
    // Watchdog: controller holds busy, write times out, next write still granted
    wr_iss_q.push_back({4'b0001, 32'h8000, 8'h00, 64'h8888});
    wr_mdl_q.push_back('{v: 1'b0, cyc: 8'd40, d: '0});
    wr_cpl_q.push_back({2'b10, 4'b0001});
    wr_req(0, 32'h8000, 8'h00, 64'h8888);
    wait_quiet("timeout_quiet");
    wr_iss_q.push_back({4'b0010, 32'h9000, 8'h01, 64'h9999});
    wr_mdl_q.push_back('{v: 1'b0, cyc: 8'd2, d: '0});
    wr_cpl_q.push_back({2'b01, 4'b0010});
    wr_req(1, 32'h9000, 8'h01, 64'h9999);
    wait_quiet("after_timeout_quiet");
`endif

    repeat (4) @(negedge clk);
    check("rd_iss_q_drained", 128'(rd_iss_q.size()), 128'(0));
    check("wr_iss_q_drained", 128'(wr_iss_q.size()), 128'(0));
    check("rd_cpl_q_drained", 128'(rd_cpl_q.size()), 128'(0));
    check("wr_cpl_q_drained", 128'(wr_cpl_q.size()), 128'(0));
    check("models_drained", 128'(rd_mdl_q.size() + wr_mdl_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
